// File: rtl/spi_engine_offload.sv
// Offload engine: replays a pre-loaded SPI Engine command/SDO program each time
// the trigger fires, and passes SDI and sync traffic straight through.
module spi_engine_offload #(
  parameter int CMD_MEM_ADDR_WIDTH = 4,
  parameter int SDO_MEM_ADDR_WIDTH = 4
) (
  input  logic        spi_clk,
  input  logic        spi_resetn,
  input  logic        trigger,

  input  logic        ctrl_cmd_wr_en,
  input  logic [15:0] ctrl_cmd_wr_data,
  input  logic        ctrl_sdo_wr_en,
  input  logic [7:0]  ctrl_sdo_wr_data,
  input  logic        ctrl_mem_reset,
  input  logic        ctrl_enable,
  output logic        ctrl_enabled,

  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd,

  output logic        sdo_data_valid,
  input  logic        sdo_data_ready,
  output logic [7:0]  sdo_data,

  input  logic        sdi_data_valid,
  output logic        sdi_data_ready,
  input  logic [7:0]  sdi_data,

  input  logic        sync_valid,
  output logic        sync_ready,
  input  logic [7:0]  sync_data,

  output logic        offload_sdi_valid,
  input  logic        offload_sdi_ready,
  output logic [7:0]  offload_sdi_data
);

  localparam int CW = CMD_MEM_ADDR_WIDTH;
  localparam int SW = SDO_MEM_ADDR_WIDTH;
  localparam logic [CW:0] CMD_MAX = {1'b1, {CW{1'b0}}};
  localparam logic [SW:0] SDO_MAX = {1'b1, {SW{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_SYNC} state_t;

  state_t        state, state_next;
  logic [15:0]   cmd_mem [2**CW];
  logic [7:0]    sdo_mem [2**SW];
  logic [CW:0]   cmd_len;
  logic [SW:0]   sdo_len;
  logic [CW-1:0] cmd_rd;
  logic [SW-1:0] sdo_rd;
  logic          enable_reg;

  logic is_idle, start, cmd_hs, sdo_hs, cmd_last, sdo_last;
  logic cmd_we, sdo_we, mem_clr;

  assign is_idle  = (state == IDLE);
  assign start    = is_idle & enable_reg & trigger & (cmd_len != '0);
  assign cmd_hs   = cmd_valid & cmd_ready;
  assign sdo_hs   = sdo_data_valid & sdo_data_ready;
  assign cmd_last = ({1'b0, cmd_rd} == cmd_len - 1'b1);
  assign sdo_last = ({1'b0, sdo_rd} == sdo_len - 1'b1);

  // The program can only change between passes; a clear beats a coincident write.
  assign mem_clr = is_idle & ctrl_mem_reset;
  assign cmd_we  = is_idle & ~ctrl_mem_reset & ctrl_cmd_wr_en & (cmd_len != CMD_MAX);
  assign sdo_we  = is_idle & ~ctrl_mem_reset & ctrl_sdo_wr_en & (sdo_len != SDO_MAX);

  // NOTE: storage arrays have no reset; the length registers define which entries are valid.
  always_ff @(posedge spi_clk) begin
    if (cmd_we) cmd_mem[cmd_len[CW-1:0]] <= ctrl_cmd_wr_data;
    if (sdo_we) sdo_mem[sdo_len[SW-1:0]] <= ctrl_sdo_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state      <= IDLE;
      cmd_len    <= '0;
      sdo_len    <= '0;
      cmd_rd     <= '0;
      sdo_rd     <= '0;
      enable_reg <= 1'b0;
    end else begin
      state      <= state_next;
      enable_reg <= ctrl_enable;

      if (mem_clr) begin
        cmd_len <= '0;
        sdo_len <= '0;
      end else begin
        if (cmd_we) cmd_len <= cmd_len + 1'b1;
        if (sdo_we) sdo_len <= sdo_len + 1'b1;
      end

      if (start) begin
        cmd_rd <= '0;
        sdo_rd <= '0;
      end else begin
        if (cmd_hs) cmd_rd <= cmd_rd + 1'b1;
        if (sdo_hs) sdo_rd <= sdo_last ? '0 : sdo_rd + 1'b1;
      end
    end
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = ACTIVE;
      ACTIVE:    if (cmd_hs && cmd_last) state_next = WAIT_SYNC;
      WAIT_SYNC: if (sync_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign cmd_valid      = (state == ACTIVE);
  assign cmd            = cmd_mem[cmd_rd];
  assign sdo_data_valid = ~is_idle & (sdo_len != '0);
  assign sdo_data       = sdo_mem[sdo_rd];
  assign ctrl_enabled   = enable_reg | ~is_idle;

  assign offload_sdi_valid = sdi_data_valid;
  assign offload_sdi_data  = sdi_data;
  assign sdi_data_ready    = offload_sdi_ready;
  assign sync_ready        = 1'b1;

  // The sync id carries no meaning for replay; fold it into a deliberately unused net.
  logic unused_sync;
  assign unused_sync = ^sync_data;

endmodule

// File: tb/tb_spi_engine_offload.sv
// Directed self-checking bench for spi_engine_offload: replay order, stalls,
// SDO wrap, capacity, disable mid-pass, ignored control writes and async reset.
module tb_spi_engine_offload;

  logic        spi_clk = 1'b0;
  logic        spi_resetn;
  logic        trigger;
  logic        ctrl_cmd_wr_en;
  logic [15:0] ctrl_cmd_wr_data;
  logic        ctrl_sdo_wr_en;
  logic [7:0]  ctrl_sdo_wr_data;
  logic        ctrl_mem_reset;
  logic        ctrl_enable;
  logic        ctrl_enabled;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd;
  logic        sdo_data_valid;
  logic        sdo_data_ready;
  logic [7:0]  sdo_data;
  logic        sdi_data_valid;
  logic        sdi_data_ready;
  logic [7:0]  sdi_data;
  logic        sync_valid;
  logic        sync_ready;
  logic [7:0]  sync_data;
  logic        offload_sdi_valid;
  logic        offload_sdi_ready;
  logic [7:0]  offload_sdi_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] got_q[$];
  logic [7:0]  sdo_q[$];

  always #5 spi_clk = ~spi_clk;

  spi_engine_offload #(.CMD_MEM_ADDR_WIDTH(4), .SDO_MEM_ADDR_WIDTH(4)) dut (
    .spi_clk(spi_clk), .spi_resetn(spi_resetn), .trigger(trigger),
    .ctrl_cmd_wr_en(ctrl_cmd_wr_en), .ctrl_cmd_wr_data(ctrl_cmd_wr_data),
    .ctrl_sdo_wr_en(ctrl_sdo_wr_en), .ctrl_sdo_wr_data(ctrl_sdo_wr_data),
    .ctrl_mem_reset(ctrl_mem_reset), .ctrl_enable(ctrl_enable), .ctrl_enabled(ctrl_enabled),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .sdo_data_valid(sdo_data_valid), .sdo_data_ready(sdo_data_ready), .sdo_data(sdo_data),
    .sdi_data_valid(sdi_data_valid), .sdi_data_ready(sdi_data_ready), .sdi_data(sdi_data),
    .sync_valid(sync_valid), .sync_ready(sync_ready), .sync_data(sync_data),
    .offload_sdi_valid(offload_sdi_valid), .offload_sdi_ready(offload_sdi_ready),
    .offload_sdi_data(offload_sdi_data)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic wr_cmd(input logic [15:0] d);
    ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_data = d;
    step();
    ctrl_cmd_wr_en = 1'b0;
  endtask

  task automatic wr_sdo(input logic [7:0] d);
    ctrl_sdo_wr_en = 1'b1; ctrl_sdo_wr_data = d;
    step();
    ctrl_sdo_wr_en = 1'b0;
  endtask

  task automatic fire();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic do_sync();
    sync_valid = 1'b1;
    step();
    sync_valid = 1'b0;
  endtask

  // Accept words with cmd_ready=1 until cmd_valid drops or the cycle budget expires.
  task automatic collect_cmds(input int max_cycles);
    got_q.delete();
    cmd_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (!cmd_valid) break;
      got_q.push_back(cmd);
      step();
    end
    check("collect_done", {31'd0, cmd_valid}, 32'd0);
  endtask

  initial begin
    spi_resetn = 1'b0; trigger = 1'b0;
    ctrl_cmd_wr_en = 1'b0; ctrl_cmd_wr_data = '0;
    ctrl_sdo_wr_en = 1'b0; ctrl_sdo_wr_data = '0;
    ctrl_mem_reset = 1'b0; ctrl_enable = 1'b0;
    cmd_ready = 1'b0; sdo_data_ready = 1'b0;
    sdi_data_valid = 1'b0; sdi_data = '0;
    sync_valid = 1'b0; sync_data = '0; offload_sdi_ready = 1'b0;

    step(); step();
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_sdo_valid", {31'd0, sdo_data_valid}, 32'd0);
    check("rst_enabled",   {31'd0, ctrl_enabled}, 32'd0);
    @(negedge spi_clk) spi_resetn = 1'b1;
    step();

    // Pass-through paths
    sdi_data_valid = 1'b1; sdi_data = 8'h3C; offload_sdi_ready = 1'b1; sync_data = 8'h77;
    #1;
    check("sdi_valid_pt", {31'd0, offload_sdi_valid}, 32'd1);
    check("sdi_data_pt",  {24'd0, offload_sdi_data}, 32'h3C);
    check("sdi_ready_pt", {31'd0, sdi_data_ready}, 32'd1);
    check("sync_ready",   {31'd0, sync_ready}, 32'd1);
    sdi_data_valid = 1'b0; offload_sdi_ready = 1'b0;
    #1;
    check("sdi_ready_pt0", {31'd0, sdi_data_ready}, 32'd0);

    // Basic replay: three words, one cycle after trigger
    wr_cmd(16'h1001); wr_cmd(16'h2002); wr_cmd(16'h3003);
    ctrl_enable = 1'b1;
    step();
    check("t1_enabled", {31'd0, ctrl_enabled}, 32'd1);
    cmd_ready = 1'b1;
    trigger = 1'b1;
    #1;
    check("t1_pre_valid", {31'd0, cmd_valid}, 32'd0);
    step();
    trigger = 1'b0;
    check("t1_latency", {31'd0, cmd_valid}, 32'd1);
    collect_cmds(20);
    check("t1_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t1_w0", {16'd0, got_q[0]}, 32'h1001);
      check("t1_w1", {16'd0, got_q[1]}, 32'h2002);
      check("t1_w2", {16'd0, got_q[2]}, 32'h3003);
    end
    check("t1_wait_enabled", {31'd0, ctrl_enabled}, 32'd1);
    do_sync();
    check("t1_idle_valid", {31'd0, cmd_valid}, 32'd0);
    check("t1_idle_enabled", {31'd0, ctrl_enabled}, 32'd1);

    // Back-pressure holds the current word
    cmd_ready = 1'b0;
    fire();
    check("t2_first", {16'd0, cmd}, 32'h1001);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_hold_data%0d", i), {16'd0, cmd}, 32'h2002);
      check($sformatf("t2_hold_valid%0d", i), {31'd0, cmd_valid}, 32'd1);
    end
    collect_cmds(20);
    check("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_w1", {16'd0, got_q[0]}, 32'h2002);
      check("t2_w2", {16'd0, got_q[1]}, 32'h3003);
    end
    do_sync();

    // SDO wrap within a pass, restart at the next pass
    wr_sdo(8'hA5); wr_sdo(8'h5A);
    cmd_ready = 1'b0;
    fire();
    sdo_data_ready = 1'b1;
    sdo_q.delete();
    for (int i = 0; i < 5; i++) begin
      if (sdo_data_valid) sdo_q.push_back(sdo_data);
      step();
    end
    sdo_data_ready = 1'b0;
    check("t3_sdo_count", sdo_q.size(), 5);
    if (sdo_q.size() == 5) begin
      check("t3_b0", {24'd0, sdo_q[0]}, 32'hA5);
      check("t3_b1", {24'd0, sdo_q[1]}, 32'h5A);
      check("t3_b2", {24'd0, sdo_q[2]}, 32'hA5);
      check("t3_b3", {24'd0, sdo_q[3]}, 32'h5A);
      check("t3_b4", {24'd0, sdo_q[4]}, 32'hA5);
    end
    collect_cmds(20);
    do_sync();
    check("t3_idle_sdo_valid", {31'd0, sdo_data_valid}, 32'd0);
    cmd_ready = 1'b0;
    fire();
    check("t3_restart_valid", {31'd0, sdo_data_valid}, 32'd1);
    check("t3_restart_byte", {24'd0, sdo_data}, 32'hA5);
    collect_cmds(20);
    do_sync();

    // Control writes and clears during a pass are ignored
    cmd_ready = 1'b0;
    fire();
    ctrl_mem_reset = 1'b1; ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_data = 16'hDEAD;
    step();
    ctrl_mem_reset = 1'b0; ctrl_cmd_wr_en = 1'b0;
    collect_cmds(20);
    check("t4_count", got_q.size(), 3);
    if (got_q.size() == 3) check("t4_w2", {16'd0, got_q[2]}, 32'h3003);
    do_sync();
    ctrl_mem_reset = 1'b1;
    step();
    ctrl_mem_reset = 1'b0;
    fire();
    step();
    check("t4_empty_no_pass", {31'd0, cmd_valid}, 32'd0);

    // Capacity: the 17th word is dropped
    for (int i = 0; i < 17; i++) wr_cmd(16'h0100 + 16'(i));
    fire();
    collect_cmds(40);
    check("t5_count", got_q.size(), 16);
    if (got_q.size() == 16)
      for (int i = 0; i < 16; i++) check($sformatf("t5_w%0d", i), {16'd0, got_q[i]}, 32'h0100 + i);
    do_sync();

    // Disable mid-pass: the pass completes, then no further passes
    cmd_ready = 1'b0;
    fire();
    ctrl_enable = 1'b0;
    step(); step();
    check("t6_active_enabled", {31'd0, ctrl_enabled}, 32'd1);
    collect_cmds(40);
    check("t6_count", got_q.size(), 16);
    check("t6_wait_enabled", {31'd0, ctrl_enabled}, 32'd1);
    do_sync();
    check("t6_enabled_fell", {31'd0, ctrl_enabled}, 32'd0);
    trigger = 1'b1;
    step(); step();
    check("t6_no_pass", {31'd0, cmd_valid}, 32'd0);
    trigger = 1'b0;

    // Async reset mid-pass
    ctrl_mem_reset = 1'b1;
    step();
    ctrl_mem_reset = 1'b0;
    wr_cmd(16'h4004); wr_sdo(8'hC3);
    ctrl_enable = 1'b1;
    step();
    cmd_ready = 1'b0;
    fire();
    check("t7_pre_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check("t7_pre_sdo_valid", {31'd0, sdo_data_valid}, 32'd1);
    #2 spi_resetn = 1'b0;
    #1;
    check("t7_rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("t7_rst_sdo_valid", {31'd0, sdo_data_valid}, 32'd0);
    @(negedge spi_clk) spi_resetn = 1'b1;
    step(); step();
    fire();
    step();
    check("t7_len_cleared", {31'd0, cmd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_engine_offload.md
Name: spi_engine_offload

Overview:
Replays a pre-loaded SPI Engine command/SDO program each time an external trigger fires, without CPU involvement. It sits directly downstream of the AXI SPI Engine control block. It is loaded through that block's offload control strobes (cmd/sdo write enables, mem reset, enable). It drives an SPI Engine cmd/sdo stream toward the interconnect/execution stage and forwards returned SDI bytes to an offload sink.

Parameters:
CMD_MEM_ADDR_WIDTH, 4, log2 of command memory depth (16-bit entries)
SDO_MEM_ADDR_WIDTH, 4, log2 of SDO memory depth (8-bit entries)

Ports:
spi_clk  input  1  single clock for all logic
spi_resetn  input  1  asynchronous active-low reset
trigger  input  1  level trigger; starts one program pass
ctrl_cmd_wr_en  input  1  append ctrl_cmd_wr_data to command memory
ctrl_cmd_wr_data  input  16  command word
ctrl_sdo_wr_en  input  1  append ctrl_sdo_wr_data to SDO memory
ctrl_sdo_wr_data  input  8  SDO byte
ctrl_mem_reset  input  1  one-cycle pulse; clears both memory lengths
ctrl_enable  input  1  offload enable
ctrl_enabled  output  1  enable register OR pass in progress
cmd_valid  output  1  command stream valid
cmd_ready  input  1  command stream ready
cmd  output  16  command word
sdo_data_valid  output  1  SDO stream valid
sdo_data_ready  input  1  SDO stream ready
sdo_data  output  8  SDO byte
sdi_data_valid  input  1  SDI from engine
sdi_data_ready  output  1  = offload_sdi_ready
sdi_data  input  8  SDI byte
sync_valid  input  1  sync from engine
sync_ready  output  1  constant 1
sync_data  input  8  sync id (ignored)
offload_sdi_valid  output  1  = sdi_data_valid
offload_sdi_ready  input  1  downstream ready
offload_sdi_data  output  8  = sdi_data

Behaviour:
- Reset (async assert, sync deassert usage): state IDLE; cmd_len=0, sdo_len=0; all read pointers 0; enable reg 0; cmd_valid=0, sdo_data_valid=0, ctrl_enabled=0.
- Lengths are ADDR_WIDTH+1 bits wide. Max cmd_len = 2^CMD_MEM_ADDR_WIDTH; max sdo_len = 2^SDO_MEM_ADDR_WIDTH.
- Memory writes:
  - A write stores at address len and increments len in the same cycle.
  - A write is dropped when len is at max.
  - A write is dropped when the state is not IDLE.
- ctrl_mem_reset: in IDLE, sets cmd_len=0 and sdo_len=0 next cycle. Ignored while not IDLE. If it coincides with a write, the reset wins.
- Enable register: follows ctrl_enable every cycle.
- ctrl_enabled = enable_reg | (state != IDLE). Deassertion therefore waits for the current pass to finish.
- State machine:
  - IDLE -> ACTIVE when enable_reg & trigger & cmd_len != 0. On this transition, cmd_rd=0 and sdo_rd=0.
  - ACTIVE: cmd_valid=1, cmd = cmd_mem[cmd_rd] (asynchronous read). On cmd_valid & cmd_ready, cmd_rd increments. If the handshake is on entry cmd_len-1, go to WAIT_SYNC.
  - WAIT_SYNC: cmd_valid=0. On sync_valid go to IDLE.
  - A sync_valid seen in ACTIVE is ignored.
- Latency: trigger sampled high in cycle N in IDLE -> cmd_valid high in cycle N+1.
- SDO stream:
  - sdo_data_valid = (state != IDLE) & sdo_len != 0; sdo_data = sdo_mem[sdo_rd].
  - On handshake, sdo_rd increments and wraps to 0 after entry sdo_len-1.
  - sdo_rd resets to 0 at each pass start.
- Disabling mid-pass does not abort the pass; no new pass starts once enable_reg=0.
- trigger held high produces back-to-back passes, separated by at least one IDLE cycle.
- SDI and sync paths are purely combinational pass-through. sync_ready is tied to 1.

Test Plan:
- Load cmds 0x1001,0x2002,0x3003; enable; trigger pulse; cmd_ready=1 -> cmd_valid for exactly 3 cycles starting 1 cycle after trigger, data in order. After sync_valid: IDLE, ctrl_enabled stays 1.
- Hold cmd_ready=0 for 5 cycles mid-pass -> cmd holds 0x2002 stable with cmd_valid=1. No word is skipped or duplicated.
- Load 2 SDO bytes 0xA5,0x5A; engine pulls 5 bytes in one pass -> A5,5A,A5,5A,A5. Second pass restarts at A5.
- Write 17 cmds with CMD_MEM_ADDR_WIDTH=4 -> 17th dropped; a pass emits 16 words.
- Clear ctrl_enable during ACTIVE -> pass completes. ctrl_enabled falls the cycle after sync_valid; a further trigger produces no cmd_valid.
- ctrl_mem_reset and writes while ACTIVE -> ignored; replay unchanged. Same mem_reset in IDLE -> next trigger produces no pass (cmd_len=0).
- Async reset asserted mid-pass -> cmd_valid and sdo_data_valid go 0 immediately; cmd_len=0 afterwards.
